// File: rtl/alu_sequencer.sv
// Program sequencer driving a byte ALU from a 16-entry instruction store.
// Supports EXEC / BR-on-flags / OUT / HALT, with an instruction-retire limit per run.
module alu_sequencer #(
  parameter int unsigned MAX_STEPS = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [13:0] prog_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [3:0]  alu_opcode,
  output logic [7:0]  alu_data,
  input  logic [7:0]  alu_result,
  output logic [7:0]  out_data,
  output logic        out_valid
);

  localparam int unsigned PC_W   = 4;
  localparam int unsigned STEP_W = 8;
  localparam int unsigned INSN_W = 14;
  localparam int unsigned DEPTH  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STAT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] CTL_EXEC = 2'b00;
  localparam logic [1:0] CTL_BR   = 2'b01;
  localparam logic [1:0] CTL_OUT  = 2'b10;
  localparam logic [1:0] CTL_HALT = 2'b11;

  state_t              r_state;
  logic [INSN_W-1:0]   r_mem [DEPTH];
  logic [PC_W-1:0]     r_pc;
  logic [STEP_W-1:0]   r_steps;

  logic [INSN_W-1:0]   w_insn;
  logic [1:0]          w_ctl;
  logic [3:0]          w_op;
  logic [7:0]          w_operand;
  logic [3:0]          w_mask;
  logic [PC_W-1:0]     w_target;
  logic                w_limit;
  logic                w_taken;

  assign w_insn    = r_mem[r_pc];
  assign w_ctl     = w_insn[13:12];
  assign w_op      = w_insn[11:8];
  assign w_operand = w_insn[7:0];
  assign w_mask    = w_operand[7:4];
  assign w_target  = w_operand[3:0];
  assign w_limit   = (r_steps == STEP_W'(MAX_STEPS));
  // In STAT, pc still points at the BR word and alu_result carries the status byte
  assign w_taken   = ((alu_result[3:0] & w_mask) != 4'h0);

  // ALU drive: only EXEC and BR (status request) issue anything, and never on the limit cycle
  always_comb begin
    alu_opcode = 4'h0;
    alu_data   = 8'h00;
    if (r_state == S_RUN && !w_limit) begin
      case (w_ctl)
        CTL_EXEC: begin
          alu_opcode = w_op;
          alu_data   = w_operand;
        end
        CTL_BR:  alu_opcode = 4'hF;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_steps   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (prog_we) r_mem[prog_addr] <= prog_data;
          if (start) begin
            r_pc    <= '0;
            r_steps <= '0;
            timeout <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_limit) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            case (w_ctl)
              CTL_EXEC: begin
                r_pc    <= r_pc + PC_W'(1);
                r_steps <= r_steps + STEP_W'(1);
              end
              CTL_OUT: begin
                out_data  <= alu_result;
                out_valid <= 1'b1;
                r_pc      <= r_pc + PC_W'(1);
                r_steps   <= r_steps + STEP_W'(1);
              end
              CTL_BR:  r_state <= S_STAT;
              default: begin
                done    <= 1'b1;
                r_state <= S_DONE;
              end
            endcase
          end
        end
        S_STAT: begin
          r_pc    <= w_taken ? w_target : r_pc + PC_W'(1);
          r_steps <= r_steps + STEP_W'(1);
          r_state <= S_RUN;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, instruction-level reference interpreter,
// directed programs plus random programs.
module tb_alu_sequencer;

  localparam int unsigned LIMIT = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [13:0] prog_data;
  logic        start;
  logic        busy, done, timeout, out_valid;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_data, alu_result, out_data;

  alu_sequencer #(.MAX_STEPS(LIMIT)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .busy(busy), .done(done),
    .timeout(timeout), .alu_opcode(alu_opcode), .alu_data(alu_data),
    .alu_result(alu_result), .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Byte ALU: 1 load, 2 add (sets carry), 3 xor, F exposes status {carry,neg,zero} next cycle
  logic [7:0] a_acc;
  logic       a_carry, a_stat;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_acc <= 8'h00; a_carry <= 1'b0; a_stat <= 1'b0;
    end else begin
      a_stat <= (alu_opcode == 4'hF);
      case (alu_opcode)
        4'h1: begin a_acc <= alu_data; a_carry <= 1'b0; end
        4'h2: {a_carry, a_acc} <= {1'b0, a_acc} + {1'b0, alu_data};
        4'h3: begin a_acc <= a_acc ^ alu_data; a_carry <= 1'b0; end
        default: ;
      endcase
    end
  end
  assign alu_result = a_stat ? {5'b0, a_carry, a_acc[7], (a_acc == 8'h00)} : a_acc;

  logic [7:0] obs_q[$];
  always @(negedge clk) if (out_valid) obs_q.push_back(out_data);

  int n_chk = 0, n_fail = 0;
  logic [13:0] prog [16];
  logic [7:0]  m_acc;
  logic        m_carry;
  logic [7:0]  exp_q[$];
  int          exp_cycles;
  logic        exp_tmo;
  int          base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [13:0] ins(input logic [1:0] c, input logic [3:0] o, input logic [7:0] d);
    return {c, o, d};
  endfunction

  function automatic logic [7:0] m_status();
    return {5'b0, m_carry, m_acc[7], (m_acc == 8'h00)};
  endfunction

  // Instruction-level interpreter; cycles counts edges from the start-sampling edge to done
  task automatic model_run();
    int pc = 0, steps = 0;
    bit stat = 0;
    logic [13:0] w;
    logic [8:0]  sum;
    exp_q.delete();
    exp_cycles = 1;
    exp_tmo = 1'b0;
    forever begin
      w = prog[pc];
      exp_cycles++;
      if (steps == int'(LIMIT)) begin exp_tmo = 1'b1; break; end
      if (w[13:12] == 2'b11) break;
      case (w[13:12])
        2'b00: begin
          case (w[11:8])
            4'h1: begin m_acc = w[7:0]; m_carry = 1'b0; end
            4'h2: begin sum = {1'b0, m_acc} + {1'b0, w[7:0]}; m_acc = sum[7:0]; m_carry = sum[8]; end
            4'h3: begin m_acc = m_acc ^ w[7:0]; m_carry = 1'b0; end
            default: ;
          endcase
          stat = (w[11:8] == 4'hF);
          pc = (pc + 1) % 16;
        end
        2'b10: begin
          exp_q.push_back(stat ? m_status() : m_acc);
          stat = 0;
          pc = (pc + 1) % 16;
        end
        default: begin
          exp_cycles++;
          if ((m_status() & {4'h0, w[7:4]}) != 8'h00) pc = int'(w[3:0]);
          else pc = (pc + 1) % 16;
          stat = 0;
        end
      endcase
      steps++;
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Runs the loaded program against the model; poke drives start+write mid-run
  task automatic run_check(input string tag, input bit poke);
    int edges, n;
    model_run();
    base = obs_q.size();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    edges = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && edges < 300) begin
      if (poke && edges == 3) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'h0; prog_data = ins(2'b11, 4'h0, 8'h00);
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
      @(posedge clk); #1 edges++;
    end
    start = 1'b0; prog_we = 1'b0;
    check({tag, "_cycles"}, 32'(edges), 32'(exp_cycles));
    check({tag, "_timeout"}, 32'(timeout), 32'(exp_tmo));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    n = obs_q.size() - base;
    check({tag, "_nout"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check({tag, "_data"}, 32'(obs_q[base + i]), 32'(exp_q[i]));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 14'h0000;
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 14'h0; start = 1'b0;
    m_acc = 8'h00; m_carry = 1'b0;
    clear_prog();
    #12;
    check("rst_outs", {busy, done, timeout, out_valid}, 32'd0);
    check("rst_data", {8'h0, out_data, alu_opcode, alu_data}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // load 5, add 3, OUT, HALT
    clear_prog();
    prog[0] = ins(2'b00, 4'h1, 8'h05); prog[1] = ins(2'b00, 4'h2, 8'h03);
    prog[2] = ins(2'b10, 4'h0, 8'h00); prog[3] = ins(2'b11, 4'h0, 8'h00);
    load_prog();
    run_check("add", 1'b0);
    check("add_spec", {16'd0, 8'(obs_q.size() - base), obs_q[obs_q.size() - 1]}, {16'd0, 8'd1, 8'h08});

    // branch on zero taken: 0x11 skipped
    clear_prog();
    prog[0] = ins(2'b00, 4'h1, 8'h00); prog[1] = ins(2'b01, 4'h0, 8'h14);
    prog[2] = ins(2'b00, 4'h1, 8'h11); prog[3] = ins(2'b10, 4'h0, 8'h00);
    prog[4] = ins(2'b00, 4'h1, 8'h22); prog[5] = ins(2'b10, 4'h0, 8'h00);
    prog[6] = ins(2'b11, 4'h0, 8'h00);
    load_prog();
    run_check("br_taken", 1'b0);
    check("br_taken_spec", {8'(obs_q.size() - base), obs_q[base]}, {8'd1, 8'h22});

    // branch not taken: 0x11 then 0x22
    prog[0] = ins(2'b00, 4'h1, 8'h01);
    load_prog();
    run_check("br_not", 1'b0);
    check("br_not_spec", {8'(obs_q.size() - base), obs_q[base], obs_q[base + 1]}, {8'd2, 8'h11, 8'h22});

    // status capture after overflow: zero + carry
    clear_prog();
    prog[0] = ins(2'b00, 4'h1, 8'hFF); prog[1] = ins(2'b00, 4'h2, 8'h01);
    prog[2] = ins(2'b00, 4'hF, 8'h00); prog[3] = ins(2'b10, 4'h0, 8'h00);
    prog[4] = ins(2'b11, 4'h0, 8'h00);
    load_prog();
    run_check("status", 1'b0);
    check("status_spec", 32'(obs_q[obs_q.size() - 1]), 32'h05);

    // start and store write while busy are ignored, and the store is unchanged afterwards
    clear_prog();
    prog[10] = ins(2'b00, 4'h1, 8'h44); prog[11] = ins(2'b10, 4'h0, 8'h00);
    prog[12] = ins(2'b11, 4'h0, 8'h00);
    load_prog();
    run_check("busy_poke", 1'b1);
    run_check("after_poke", 1'b0);

    // reset mid-run while an EXEC is on the ALU bus
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrun_drive", {alu_opcode, alu_data}, {20'd0, 4'h1, 8'h44});
    rst = 1'b1; #1;
    check("midrun_rst", {busy, alu_opcode, alu_data}, 32'd0);
    @(negedge clk) rst = 1'b0;
    m_acc = 8'h00; m_carry = 1'b0;
    clear_prog();

    // cleared store: nops until the retire limit
    run_check("tmo", 1'b0);
    check("tmo_pc_wrap", 32'(dut.r_pc), 32'd4);
    check("tmo_hold", 32'(timeout), 32'd1);

    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 16; i++) begin
        int r;
        logic [3:0] op;
        r = int'($urandom_range(0, 9));
        case ($urandom_range(0, 4))
          0: op = 4'h0; 1: op = 4'h1; 2: op = 4'h2; 3: op = 4'h3; default: op = 4'hF;
        endcase
        if (r <= 4)      prog[i] = ins(2'b00, op, 8'($urandom));
        else if (r <= 6) prog[i] = ins(2'b10, 4'h0, 8'h00);
        else if (r <= 8) prog[i] = ins(2'b01, 4'h0, 8'($urandom));
        else             prog[i] = ins(2'b11, 4'h0, 8'h00);
      end
      load_prog();
      run_check("rand", 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
